exec_stage: RTL and testbench

Execute/commit stage of the cpu16 datapath. It sits between decode/operand fetch and register-file writeback. It accepts one decoded operation per valid/ready handshake, registers the operands, and drives the combinational ALU for exactly one cycle. It then owns the architectural zero/carry flag registers and presents the committed result to writeback with a valid/ready handshake.

---
 rtl/exec_stage.sv | 118 +++++++++++
 tb/tb_exec_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Execute/commit stage of the cpu16 datapath: registers one decoded operation,
// drives the external ALU for one cycle, owns the zero/carry flags, hands results to writeback.
module exec_stage #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [REGBITS-1:0] in_rd,
  input  logic               in_wb_en,
  input  logic               in_flags_en,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [4:0]         alu_op,
  output logic               alu_enable,
  output logic               alu_zero_in,
  output logic               alu_carry_in,
  input  logic [WIDTH:0]     alu_out,
  input  logic               alu_zero_out,
  input  logic               alu_carry_out,
  input  logic               alu_cond_met,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [REGBITS-1:0] wb_rd,
  output logic [WIDTH-1:0]   wb_data,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic [15:0]        retired
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t             state;
  logic [REGBITS-1:0] rd_q;
  logic               wb_en_q;
  logic               flags_en_q;

  // The ALU carry-out bit is consumed through alu_carry_out, never written back.
  logic alu_out_msb_unused;
  assign alu_out_msb_unused = alu_out[WIDTH];

  assign in_ready     = (state == IDLE) && !flush && !rst;
  assign alu_zero_in  = zero_flag;
  assign alu_carry_in = carry_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_q       <= '0;
      wb_en_q    <= 1'b0;
      flags_en_q <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_enable <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      retired    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            alu_a      <= in_a;
            alu_b      <= in_b;
            alu_op     <= in_op;
            rd_q       <= in_rd;
            wb_en_q    <= in_wb_en;
            flags_en_q <= in_flags_en;
            alu_enable <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          alu_enable <= 1'b0;
          // flush wins over a commit arriving in the same cycle
          if (flush || !alu_cond_met) begin
            state <= IDLE;
          end else begin
            if (flags_en_q) begin
              zero_flag  <= alu_zero_out;
              carry_flag <= alu_carry_out;
            end
            retired <= retired + 16'd1;
            wb_data <= alu_out[WIDTH-1:0];
            wb_rd   <= rd_q;
            if (wb_en_q) begin
              wb_valid <= 1'b1;
              state    <= WB;
            end else begin
              state <= IDLE;
            end
          end
        end
        WB: begin
          if (flush || wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          alu_enable <= 1'b0;
          wb_valid   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: behavioural ALU environment plus a transaction-level model
// of the architectural outputs, compared on every falling edge.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_wb_en, in_flags_en;
  logic [4:0]  in_op, alu_op;
  logic [15:0] in_a, in_b, alu_a, alu_b, wb_data, retired;
  logic [2:0]  in_rd, wb_rd;
  logic        alu_enable, alu_zero_in, alu_carry_in;
  logic [16:0] alu_out;
  logic        alu_zero_out, alu_carry_out, alu_cond_met;
  logic        wb_valid, wb_ready, zero_flag, carry_flag;

  exec_stage #(.WIDTH(16), .REGBITS(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_rd(in_rd), .in_wb_en(in_wb_en), .in_flags_en(in_flags_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_zero_in(alu_zero_in), .alu_carry_in(alu_carry_in),
    .alu_out(alu_out), .alu_zero_out(alu_zero_out), .alu_carry_out(alu_carry_out),
    .alu_cond_met(alu_cond_met),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] out;
    logic        z;
    logic        c;
    logic        cond;
  } alu_r_t;

  // Small cpu16 ALU: 0 add, 1 sub, 2 adc, 3 sbc, 4-7 add-if-zero, 8 cmp, 22-27 logic.
  function automatic alu_r_t alu_f(input logic [4:0] op, input logic [15:0] a, b,
                                   input logic z, c);
    alu_r_t r;
    logic   lg;
    r = '0;
    r.cond = 1'b1;
    lg = 1'b0;
    case (op)
      5'd0:             r.out = {1'b0, a} + {1'b0, b};
      5'd1, 5'd8:       r.out = {1'b0, a} - {1'b0, b};
      5'd2:             r.out = {1'b0, a} + {1'b0, b} + {16'd0, c};
      5'd3:             r.out = {1'b0, a} - {1'b0, b} - {16'd0, c};
      5'd4, 5'd5, 5'd6, 5'd7: begin r.out = {1'b0, a} + {1'b0, b}; r.cond = z; end
      5'd22: begin r.out = {1'b0, a & b};    lg = 1'b1; end
      5'd23: begin r.out = {1'b0, a | b};    lg = 1'b1; end
      5'd24: begin r.out = {1'b0, a ^ b};    lg = 1'b1; end
      5'd25: begin r.out = {1'b0, ~a};       lg = 1'b1; end
      5'd26: begin r.out = {1'b0, ~(a & b)}; lg = 1'b1; end
      5'd27: begin r.out = {1'b0, ~(a | b)}; lg = 1'b1; end
      default: r.out = {1'b0, a};
    endcase
    r.z = (r.out[15:0] == 16'd0);
    r.c = lg ? c : r.out[16];
    return r;
  endfunction

  alu_r_t ar;
  always_comb ar = alu_f(alu_op, alu_a, alu_b, alu_zero_in, alu_carry_in);
  assign alu_out       = ar.out;
  assign alu_zero_out  = ar.z;
  assign alu_carry_out = ar.c;
  assign alu_cond_met  = ar.cond;

  // expected architectural state
  logic        m_ready, m_wbv, m_alu_en, m_zero, m_carry;
  logic [15:0] m_retired, m_data, m_a, m_b;
  logic [4:0]  m_op;
  logic [2:0]  m_rd;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   32'(in_ready),     32'(m_ready));
      chk("wb_valid",   32'(wb_valid),     32'(m_wbv));
      chk("alu_enable", 32'(alu_enable),   32'(m_alu_en));
      chk("zero_flag",  32'(zero_flag),    32'(m_zero));
      chk("carry_flag", 32'(carry_flag),   32'(m_carry));
      chk("zero_in",    32'(alu_zero_in),  32'(m_zero));
      chk("carry_in",   32'(alu_carry_in), 32'(m_carry));
      chk("retired",    32'(retired),      32'(m_retired));
      chk("wb_data",    32'(wb_data),      32'(m_data));
      chk("alu_a",      32'(alu_a),        32'(m_a));
      chk("alu_b",      32'(alu_b),        32'(m_b));
      chk("alu_op",     32'(alu_op),       32'(m_op));
      if (m_wbv) chk("wb_rd", 32'(wb_rd), 32'(m_rd));
    end
  end

  task automatic model_reset();
    m_ready = 1'b0; m_wbv = 1'b0; m_alu_en = 1'b0; m_zero = 1'b0; m_carry = 1'b0;
    m_retired = '0; m_data = '0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
  endtask

  // Issue one operation from IDLE (called at posedge+1) and follow it to IDLE.
  task automatic do_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] rd, input bit wbe, input bit fle, input int stall,
                       input bit fl_exec, input bit fl_wb, input bit pend, input logic [15:0] pa);
    alu_r_t r;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    in_wb_en = wbe; in_flags_en = fle;
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_a = a; m_b = b; m_op = op; m_ready = 1'b0; m_alu_en = 1'b1;
    r = alu_f(op, a, b, m_zero, m_carry);
    if (fl_exec) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; m_alu_en = 1'b0;
    if (fl_exec || !r.cond) begin m_ready = 1'b1; return; end
    if (fle) begin m_zero = r.z; m_carry = r.c; end
    m_retired = m_retired + 16'd1;
    m_data = r.out[15:0];
    if (!wbe) begin m_ready = 1'b1; return; end
    m_wbv = 1'b1; m_rd = rd;
    if (pend) begin
      in_valid = 1'b1; in_op = 5'd0; in_a = pa; in_b = 16'h0001; in_rd = 3'd1;
      in_wb_en = 1'b1; in_flags_en = 1'b1;
    end
    for (int k = 0; k < stall; k++) begin
      wb_ready = 1'b0;
      @(posedge clk); #1;
    end
    if (fl_wb) begin wb_ready = 1'b0; flush = 1'b1; end
    else wb_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; wb_ready = 1'b1; m_wbv = 1'b0; m_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_rd = '0; in_wb_en = 1'b0; in_flags_en = 1'b0; wb_ready = 1'b1;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    rst = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;

    // add 0xFFFF + 1
    do_op(5'd0, 16'hFFFF, 16'h0001, 3'd2, 1, 1, 0, 0, 0, 0, 16'h0);
    chk("add_data",    32'(wb_data),    32'h0);
    chk("add_zero",    32'(zero_flag),  32'd1);
    chk("add_carry",   32'(carry_flag), 32'd1);
    chk("add_retired", 32'(retired),    32'd1);
    chk("adc_cin",     32'(alu_carry_in), 32'd1);

    // adc 1 + 0 + carry
    do_op(5'd2, 16'h0001, 16'h0000, 3'd3, 1, 1, 0, 0, 0, 0, 16'h0);
    chk("adc_data",  32'(wb_data),    32'h2);
    chk("adc_carry", 32'(carry_flag), 32'd0);
    chk("adc_zero",  32'(zero_flag),  32'd0);

    // add-if-zero with zero clear: nothing commits
    do_op(5'd4, 16'h0005, 16'h0006, 3'd4, 1, 1, 0, 0, 0, 0, 16'h0);
    chk("cf_retired", 32'(retired), 32'd2);
    chk("cf_ready",   32'(in_ready), 32'd1);

    // carry set, then logic op keeps it
    do_op(5'd0, 16'h8000, 16'h8000, 3'd1, 1, 1, 0, 0, 0, 0, 16'h0);
    do_op(5'd22, 16'h0F0F, 16'h00FF, 3'd6, 1, 1, 0, 0, 0, 0, 16'h0);
    chk("and_data",  32'(wb_data),    32'h000F);
    chk("and_carry", 32'(carry_flag), 32'd1);

    // compare: flags only
    do_op(5'd8, 16'h0005, 16'h0005, 3'd0, 0, 1, 0, 0, 0, 0, 16'h0);
    chk("cmp_zero",    32'(zero_flag),  32'd1);
    chk("cmp_carry",   32'(carry_flag), 32'd0);
    chk("cmp_retired", 32'(retired),    32'd5);

    // flush while idle: offer is refused
    flush = 1'b1; in_valid = 1'b1; in_a = 16'hABCD; m_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; m_ready = 1'b1;

    // backpressure with a pending offer, then the pending op
    do_op(5'd0, 16'h0003, 16'h0004, 3'd5, 1, 1, 5, 0, 0, 1, 16'h1111);
    do_op(5'd0, 16'h1111, 16'h0001, 3'd1, 1, 1, 0, 0, 0, 0, 16'h0);
    chk("bp_data",    32'(wb_data), 32'h1112);
    chk("bp_retired", 32'(retired), 32'd7);

    // flush during EXEC and during WB
    do_op(5'd0, 16'h8000, 16'h8000, 3'd2, 1, 1, 0, 1, 0, 0, 16'h0);
    chk("fe_carry",   32'(carry_flag), 32'd0);
    chk("fe_retired", 32'(retired),    32'd7);
    do_op(5'd0, 16'h0001, 16'h0001, 3'd7, 1, 1, 0, 0, 1, 0, 16'h0);
    chk("fw_valid",   32'(wb_valid), 32'd0);
    chk("fw_retired", 32'(retired),  32'd8);

    // async reset while in WB
    in_valid = 1'b1; in_op = 5'd0; in_a = 16'hFFFF; in_b = 16'h0001; in_rd = 3'd3;
    in_wb_en = 1'b1; in_flags_en = 1'b1; wb_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; m_a = 16'hFFFF; m_b = 16'h0001; m_op = 5'd0; m_ready = 1'b0; m_alu_en = 1'b1;
    @(posedge clk); #1;
    m_alu_en = 1'b0; m_zero = 1'b1; m_carry = 1'b1; m_retired = m_retired + 16'd1;
    m_data = 16'h0000; m_wbv = 1'b1; m_rd = 3'd3;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("ar_valid",   32'(wb_valid),   32'd0);
    chk("ar_zero",    32'(zero_flag),  32'd0);
    chk("ar_carry",   32'(carry_flag), 32'd0);
    chk("ar_retired", 32'(retired),    32'd0);
    chk("ar_ready",   32'(in_ready),   32'd0);
    @(posedge clk); #1;
    chk("ar_ready_hold", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0; wb_ready = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    chk("ar_no_wb", 32'(wb_valid), 32'd0);
    @(negedge clk); #1;
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
